conv_window_gen: RTL and testbench

//  Hardware KxK sliding-window generator feeding simpleCNN-class cores. Accepts a raster-order
//  (row-major, top-left first) pixel stream, buffers K-1 lines and emits one packed KxK window per

---
 rtl/conv_window_gen_pkg.sv | 22 ++
 rtl/conv_window_gen_if.sv | 34 +++
 rtl/conv_window_gen_line_buffer.sv | 35 +++
 rtl/conv_window_gen.sv | 168 ++++++++++++++++
 tb/tb_conv_window_gen.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_window_gen_pkg.sv
// Shared defaults, FSM state type and width helper for the KxK sliding-window generator.
package conv_window_gen_pkg;

    localparam int unsigned DefPixW   = 8;
    localparam int unsigned DefImgW   = 28;
    localparam int unsigned DefImgH   = 28;
    localparam int unsigned DefK      = 5;
    localparam int unsigned DefStride = 1;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StStream = 2'd1,
        StFlush  = 2'd2,
        StDone   = 2'd3
    } state_e;

    // Index width for a counter covering 0..n-1; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-in and window-out valid/ready streams of the window generator.
interface conv_window_gen_if #(
    parameter int unsigned PIX_W = conv_window_gen_pkg::DefPixW,
    parameter int unsigned IMG_W = conv_window_gen_pkg::DefImgW,
    parameter int unsigned IMG_H = conv_window_gen_pkg::DefImgH,
    parameter int unsigned K     = conv_window_gen_pkg::DefK
);
    import conv_window_gen_pkg::*;

    localparam int unsigned XW   = idx_width(IMG_W);
    localparam int unsigned YW   = idx_width(IMG_H);
    localparam int unsigned WinW = K * K * PIX_W;

    logic [PIX_W-1:0] pix_in;
    logic             pix_valid;
    logic             pix_ready;
    logic [WinW-1:0]  win_out;
    logic             win_valid;
    logic             win_ready;
    logic [XW-1:0]    win_x;
    logic [YW-1:0]    win_y;
    logic             win_last;

    modport master (
        output pix_in, pix_valid, win_ready,
        input  pix_ready, win_out, win_valid, win_x, win_y, win_last
    );

    modport slave (
        input  pix_in, pix_valid, win_ready,
        output pix_ready, win_out, win_valid, win_x, win_y, win_last
    );

endinterface

// File: rtl/conv_window_gen_line_buffer.sv
// K-1 line buffers; one read and one shifting write per accepted pixel at column addr.
module conv_window_gen_line_buffer
    import conv_window_gen_pkg::*;
#(
    parameter int unsigned PIX_W = DefPixW,
    parameter int unsigned IMG_W = DefImgW,
    parameter int unsigned K     = DefK,
    localparam int unsigned XW   = idx_width(IMG_W)
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [XW-1:0]              addr,
    input  logic [PIX_W-1:0]           pix,
    output logic [K-2:0][PIX_W-1:0]    col_out
);

    // Row 0 holds the most recent line, row K-2 the oldest.
    logic [PIX_W-1:0] mem [K-1][IMG_W];

    always_comb begin
        for (int i = 0; i < int'(K) - 1; i++) begin
            col_out[i] = mem[i][addr];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[0][addr] <= pix;
            for (int i = 1; i < int'(K) - 1; i++) begin
                mem[i][addr] <= mem[i-1][addr];
            end
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Raster-stream KxK sliding-window generator with programmable stride and valid/ready on
// both sides; holds the frame FSM, col/row counters, window shift registers and output register.
module conv_window_gen
    import conv_window_gen_pkg::*;
#(
    parameter int unsigned PIX_W  = DefPixW,
    parameter int unsigned IMG_W  = DefImgW,
    parameter int unsigned IMG_H  = DefImgH,
    parameter int unsigned K      = DefK,
    parameter int unsigned STRIDE = DefStride
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    conv_window_gen_if.slave        bus,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned XW    = idx_width(IMG_W);
    localparam int unsigned YW    = idx_width(IMG_H);
    localparam int unsigned WinW  = K * K * PIX_W;
    localparam int unsigned XLast = (IMG_W - K) / STRIDE * STRIDE;
    localparam int unsigned YLast = (IMG_H - K) / STRIDE * STRIDE;

    state_e             state_q, state_d;
    logic [XW-1:0]      col_q, col_d;
    logic [YW-1:0]      row_q, row_d;
    logic               valid_q, valid_d;
    logic [WinW-1:0]    out_q, out_d;
    logic [XW-1:0]      x_q, x_d;
    logic [YW-1:0]      y_q, y_d;
    logic               last_q, last_d;

    // Ascending dims put element (0,0) in the MSBs, matching the output packing.
    logic [0:K-1][0:K-1][PIX_W-1:0] win_q, win_d;
    logic [K-2:0][PIX_W-1:0]        lb_col;
    logic [K-1:0][PIX_W-1:0]        col_new;

    logic        pix_ready, accept, emit, last_pix;
    int unsigned col_i, row_i, x_i, y_i;

    assign pix_ready     = (state_q == StStream) && (!valid_q || bus.win_ready);
    assign accept        = pix_ready && bus.pix_valid && !start;
    assign last_pix      = accept && (col_i == IMG_W - 1) && (row_i == IMG_H - 1);
    assign col_new       = {lb_col, bus.pix_in};

    assign bus.pix_ready = pix_ready;
    assign bus.win_out   = out_q;
    assign bus.win_valid = valid_q;
    assign bus.win_x     = x_q;
    assign bus.win_y     = y_q;
    assign bus.win_last  = last_q;
    assign busy          = (state_q != StIdle);
    assign done          = (state_q == StDone);

    conv_window_gen_line_buffer #(
        .PIX_W (PIX_W),
        .IMG_W (IMG_W),
        .K     (K)
    ) u_line_buffer (
        .clk     (clk),
        .wr_en   (accept),
        .addr    (col_q),
        .pix     (bus.pix_in),
        .col_out (lb_col)
    );

    always_comb begin
        col_i = 32'(col_q);
        row_i = 32'(row_q);
        x_i   = col_i - (K - 1);
        y_i   = row_i - (K - 1);
        emit  = (col_i >= K - 1) && (row_i >= K - 1) &&
                ((x_i % STRIDE) == 0) && ((y_i % STRIDE) == 0);
    end

    // Window shift: oldest line enters the top row, the live pixel the bottom row.
    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int r = 0; r < int'(K); r++) begin
                for (int c = 0; c < int'(K) - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][K-1] = col_new[int'(K) - 1 - r];
            end
        end
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (start) begin
            col_d = '0;
            row_d = '0;
        end else if (accept) begin
            if (col_i == IMG_W - 1) begin
                col_d = '0;
                row_d = (row_i == IMG_H - 1) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        out_d   = out_q;
        x_d     = x_q;
        y_d     = y_q;
        last_d  = last_q;
        if (start) begin
            valid_d = 1'b0;
        end else if (accept && emit) begin
            valid_d = 1'b1;
            out_d   = win_d;
            x_d     = XW'(x_i);
            y_d     = YW'(y_i);
            last_d  = (x_i == XLast) && (y_i == YLast);
        end else if (valid_q && bus.win_ready) begin
            valid_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = StStream;
        end else begin
            unique case (state_q)
                StIdle:   state_d = StIdle;
                StStream: if (last_pix) state_d = StFlush;
                // Only the final window can still be pending once the last pixel is in.
                StFlush:  if (!valid_q || bus.win_ready) state_d = StDone;
                StDone:   state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            out_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            out_q   <= out_d;
            x_q     <= x_d;
            y_q     <= y_d;
            last_q  <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        win_q <= win_d;
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: defaults, stride-2 and 3x3 instances checked against a window-list model.
module tb_conv_window_gen;

    typedef struct {
        int           x;
        int           y;
        bit           last;
        logic [199:0] win;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_m = 1'b0, start_s = 1'b0, start_k = 1'b0;
    logic busy_m, busy_s, busy_k, done_m, done_s, done_k;
    logic [7:0] pix_v = '0;
    logic pv_v = 1'b0;
    logic rdy_v = 1'b1;
    bit   rand_ready = 1'b0;

    int total = 0;
    int bad = 0;
    int dv [3];
    int dn [3];
    exp_t q0 [$];
    exp_t q1 [$];
    exp_t q2 [$];

    bit           hold_on = 1'b0;
    logic [199:0] hold_win;
    int           hold_x, hold_y;

    always #5 clk = ~clk;

    conv_window_gen_if #(.PIX_W(8), .IMG_W(28), .IMG_H(28), .K(5)) bm ();
    conv_window_gen_if #(.PIX_W(8), .IMG_W(28), .IMG_H(28), .K(5)) bs ();
    conv_window_gen_if #(.PIX_W(4), .IMG_W(3), .IMG_H(3), .K(3)) bk ();

    assign bm.pix_in    = pix_v;
    assign bs.pix_in    = pix_v;
    assign bk.pix_in    = pix_v[3:0];
    assign bm.pix_valid = pv_v;
    assign bs.pix_valid = pv_v;
    assign bk.pix_valid = pv_v;
    assign bm.win_ready = rdy_v;
    assign bs.win_ready = rdy_v;
    assign bk.win_ready = rdy_v;

    conv_window_gen #(.PIX_W(8), .IMG_W(28), .IMG_H(28), .K(5), .STRIDE(1)) dut_m (
        .clk(clk), .rst_n(rst_n), .start(start_m), .bus(bm), .busy(busy_m), .done(done_m)
    );
    conv_window_gen #(.PIX_W(8), .IMG_W(28), .IMG_H(28), .K(5), .STRIDE(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start_s), .bus(bs), .busy(busy_s), .done(done_s)
    );
    conv_window_gen #(.PIX_W(4), .IMG_W(3), .IMG_H(3), .K(3), .STRIDE(1)) dut_k (
        .clk(clk), .rst_n(rst_n), .start(start_k), .bus(bk), .busy(busy_k), .done(done_k)
    );

    task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, want);
        end
    endtask

    function automatic int pix_val(input int r, input int c, input int w, input int off);
        return (r * w + c + off) & 255;
    endfunction

    function automatic int qsize(input int sel);
        case (sel)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic bit rdy_of(input int sel);
        case (sel)
            0:       return bm.pix_ready;
            1:       return bs.pix_ready;
            default: return bk.pix_ready;
        endcase
    endfunction

    function automatic bit busy_of(input int sel);
        case (sel)
            0:       return busy_m;
            1:       return busy_s;
            default: return busy_k;
        endcase
    endfunction

    // Expected windows in raster order of their top-left corner, packed top-left first.
    task automatic build(input int sel, input int off);
        int w, h, k, s, pw, xl, yl;
        exp_t e;
        case (sel)
            0:       begin w = 28; h = 28; k = 5; s = 1; pw = 8; end
            1:       begin w = 28; h = 28; k = 5; s = 2; pw = 8; end
            default: begin w = 3;  h = 3;  k = 3; s = 1; pw = 4; end
        endcase
        xl = (w - k) / s * s;
        yl = (h - k) / s * s;
        for (int y = 0; y <= h - k; y += s) begin
            for (int x = 0; x <= w - k; x += s) begin
                e.x = x;
                e.y = y;
                e.last = (x == xl) && (y == yl);
                e.win = '0;
                for (int r = 0; r < k; r++) begin
                    for (int c = 0; c < k; c++) begin
                        e.win = (e.win << pw) |
                                200'(pix_val(y + r, x + c, w, off) & ((1 << pw) - 1));
                    end
                end
                case (sel)
                    0:       q0.push_back(e);
                    1:       q1.push_back(e);
                    default: q2.push_back(e);
                endcase
            end
        end
    endtask

    task automatic check_win(input int sel, input int x, input int y, input bit last,
                             input logic [199:0] win);
        exp_t e;
        dv[sel]++;
        if (qsize(sel) == 0) begin
            total++;
            bad++;
            $display("FAIL win_extra[%0d]: got window x=%0d y=%0d required none", sel, x, y);
        end else begin
            case (sel)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            chk("win_data", win, e.win);
            chk("win_x", 200'(x), 200'(e.x));
            chk("win_y", 200'(y), 200'(e.y));
            chk("win_last", 200'(last), 200'(e.last));
        end
    endtask

    // Compare process: handshakes are judged half a cycle before the edge that completes them.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_on = 1'b0;
        end else begin
            if (hold_on) begin
                chk("hold_valid", 200'(bm.win_valid), 200'(1));
                chk("hold_data", 200'(bm.win_out), hold_win);
                chk("hold_xy", 200'({int'(bm.win_x), int'(bm.win_y)}), 200'({hold_x, hold_y}));
            end
            hold_on  = bm.win_valid && !rdy_v && !start_m;
            hold_win = 200'(bm.win_out);
            hold_x   = int'(bm.win_x);
            hold_y   = int'(bm.win_y);
            if (bm.win_valid && rdy_v && !start_m)
                check_win(0, int'(bm.win_x), int'(bm.win_y), bm.win_last, 200'(bm.win_out));
            if (bs.win_valid && rdy_v && !start_s)
                check_win(1, int'(bs.win_x), int'(bs.win_y), bs.win_last, 200'(bs.win_out));
            if (bk.win_valid && rdy_v && !start_k)
                check_win(2, int'(bk.win_x), int'(bk.win_y), bk.win_last, 200'(bk.win_out));
            if (done_m) dn[0]++;
            if (done_s) dn[1]++;
            if (done_k) dn[2]++;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) rdy_v = ($urandom_range(0, 99) < 60);
    end

    task automatic begin_frame(input int sel, input int off);
        case (sel)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
        build(sel, off);
        dv[sel] = 0;
        dn[sel] = 0;
        case (sel)
            0:       start_m = 1'b1;
            1:       start_s = 1'b1;
            default: start_k = 1'b1;
        endcase
        @(posedge clk);
        #1;
        start_m = 1'b0;
        start_s = 1'b0;
        start_k = 1'b0;
    endtask

    task automatic feed(input int sel, input int w, input int off, input int vpct,
                        input int npix);
        int n = 0;
        int guard = 0;
        bit acc;
        while (n < npix && guard < npix * 20 + 100) begin
            pix_v = 8'(pix_val(n / w, n % w, w, off));
            pv_v  = ($urandom_range(0, 99) < vpct);
            @(negedge clk);
            acc = pv_v && rdy_of(sel);
            @(posedge clk);
            #1;
            guard++;
            if (acc) n++;
        end
        pv_v = 1'b0;
        chk("feed_accepted", 200'(n), 200'(npix));
    endtask

    task automatic frame_end(input int sel, input int nwin);
        int guard = 0;
        while (dn[sel] == 0 && guard < 400) begin
            @(posedge clk);
            #1;
            guard++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("done_pulses", 200'(dn[sel]), 200'(1));
        chk("win_count", 200'(dv[sel]), 200'(nwin));
        chk("queue_empty", 200'(qsize(sel)), 200'(0));
        chk("busy_idle", 200'(busy_of(sel)), 200'(0));
    endtask

    task automatic check_main_zero(input string tag);
        chk({tag, "_valid"}, 200'(bm.win_valid), 200'(0));
        chk({tag, "_out"}, 200'(bm.win_out), 200'(0));
        chk({tag, "_xy"}, 200'({bm.win_x, bm.win_y}), 200'(0));
        chk({tag, "_last"}, 200'(bm.win_last), 200'(0));
        chk({tag, "_busy"}, 200'(busy_m), 200'(0));
        chk({tag, "_done"}, 200'(done_m), 200'(0));
        chk({tag, "_pix_ready"}, 200'(bm.pix_ready), 200'(0));
    endtask

    initial begin
        int nlast;
        for (int i = 0; i < 3; i++) begin
            dv[i] = 0;
            dn[i] = 0;
        end
        #3;
        check_main_zero("reset");
        chk("reset_s2_valid", 200'(bs.win_valid), 200'(0));
        chk("reset_k3_valid", 200'(bk.win_valid), 200'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pv_v = 1'b1;
        @(negedge clk);
        chk("idle_pix_ready", 200'(bm.pix_ready), 200'(0));
        @(posedge clk);
        #1;
        pv_v = 1'b0;

        // Stall-free ramp frame, model pinned by hand-computed values.
        begin_frame(0, 0);
        chk("model_count", 200'(q0.size()), 200'(576));
        chk("model_first_rows", 200'(q0[0].win[199:120]), 200'(80'h00010203041C1D1E1F20));
        chk("model_last_xy", 200'({q0[575].x, q0[575].y}), 200'({32'd23, 32'd23}));
        nlast = 0;
        foreach (q0[i]) if (q0[i].last) nlast++;
        chk("model_last_unique", 200'(nlast), 200'(1));
        feed(0, 28, 0, 100, 784);
        frame_end(0, 576);

        // Random stalls on both sides.
        rand_ready = 1'b1;
        begin_frame(0, 8'h37);
        feed(0, 28, 8'h37, 70, 784);
        frame_end(0, 576);
        rand_ready = 1'b0;
        rdy_v = 1'b1;

        // Abort after 300 pixels, then a full re-fed frame.
        begin_frame(0, 0);
        feed(0, 28, 0, 100, 300);
        begin_frame(0, 0);
        @(negedge clk);
        chk("abort_valid", 200'(bm.win_valid), 200'(0));
        chk("abort_busy", 200'(busy_m), 200'(1));
        @(posedge clk);
        #1;
        feed(0, 28, 0, 100, 784);
        frame_end(0, 576);

        // Reset while the final window waits in FLUSH.
        begin_frame(0, 8'h21);
        feed(0, 28, 8'h21, 100, 784);
        rdy_v = 1'b0;
        @(negedge clk);
        chk("flush_busy", 200'(busy_m), 200'(1));
        chk("flush_valid", 200'(bm.win_valid), 200'(1));
        chk("flush_last", 200'(bm.win_last), 200'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check_main_zero("midreset");
        q0.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rdy_v = 1'b1;
        @(posedge clk);
        #1;
        begin_frame(0, 8'h11);
        feed(0, 28, 8'h11, 100, 784);
        frame_end(0, 576);

        // Stride 2: last pixel completes no window, DONE follows FLUSH.
        begin_frame(1, 0);
        chk("s2_model_count", 200'(q1.size()), 200'(144));
        chk("s2_model_last", 200'({q1[143].x, q1[143].y, 32'(q1[143].last)}),
            200'({32'd22, 32'd22, 32'd1}));
        feed(1, 28, 0, 100, 784);
        @(negedge clk);
        chk("s2_flush_busy", 200'(busy_s), 200'(1));
        chk("s2_flush_novalid", 200'(bs.win_valid), 200'(0));
        chk("s2_flush_nodone", 200'(done_s), 200'(0));
        @(negedge clk);
        chk("s2_done", 200'(done_s), 200'(1));
        @(posedge clk);
        #1;
        frame_end(1, 144);

        // 3x3 image, 3x3 kernel, 4-bit pixels: a single window.
        begin_frame(2, 5);
        chk("k3_model_count", 200'(q2.size()), 200'(1));
        chk("k3_model_win", 200'(q2[0].win[35:0]), 200'(36'h56789ABCD));
        chk("k3_model_last", 200'(q2[0].last), 200'(1));
        feed(2, 3, 5, 100, 9);
        frame_end(2, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
